// File: rtl/tlb_match_pipe_if.sv
// ----------------------------------------------------------------------------
// tlb_match_pipe_if
// Bundles the three groups of signals of the TLB lookup pipe:
//   search request  : s_valid, s_ready, s_vppn, s_asid
//   search result   : r_valid, r_ready, r_found, r_multi, r_index, r_ppn
//   entry maintenance: we, w_index, w_e, w_g, w_vppn, w_asid, w_ppn, inv_all
// modport slave  : the TLB side (receives searches and writes, produces results)
// modport master : the requester side (EX-stage generator / MEM-stage consumer / TLB writer)
// ----------------------------------------------------------------------------
interface tlb_match_pipe_if #(
    parameter int VPPN_W = 19,
    parameter int ASID_W = 10,
    parameter int PPN_W  = 20
);
    // search request
    logic              s_valid;
    logic              s_ready;
    logic [VPPN_W-1:0] s_vppn;
    logic [ASID_W-1:0] s_asid;

    // search result
    logic              r_valid;
    logic              r_ready;
    logic              r_found;
    logic              r_multi;
    logic [3:0]        r_index;
    logic [PPN_W-1:0]  r_ppn;

    // entry write / invalidate
    logic              we;
    logic [3:0]        w_index;
    logic              w_e;
    logic              w_g;
    logic [VPPN_W-1:0] w_vppn;
    logic [ASID_W-1:0] w_asid;
    logic [PPN_W-1:0]  w_ppn;
    logic              inv_all;

    modport slave (
        input  s_valid, s_vppn, s_asid,
        output s_ready,
        output r_valid, r_found, r_multi, r_index, r_ppn,
        input  r_ready,
        input  we, w_index, w_e, w_g, w_vppn, w_asid, w_ppn, inv_all
    );

    modport master (
        output s_valid, s_vppn, s_asid,
        input  s_ready,
        input  r_valid, r_found, r_multi, r_index, r_ppn,
        output r_ready,
        output we, w_index, w_e, w_g, w_vppn, w_asid, w_ppn, inv_all
    );
endinterface

// File: rtl/tlb_match_pipe.sv
// ----------------------------------------------------------------------------
// tlb_match_pipe
// 16-entry fully-associative TLB lookup with a two-stage valid/ready pipeline.
//   Stage A captures the one-hot match vector and the OR-selected PPN.
//   Stage B turns the match vector into found / multi / encoded index and
//   drives the result outputs.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of tlb_match_pipe_if (search, result, entry write)
// ----------------------------------------------------------------------------
module tlb_match_pipe #(
    parameter int TLBNUM = 16,
    parameter int VPPN_W = 19,
    parameter int ASID_W = 10,
    parameter int PPN_W  = 20
) (
    input  logic            clk,
    input  logic            reset,
    tlb_match_pipe_if.slave bus
);

    localparam int IDX_W = 4;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // OR-encode a one-hot vector into an index, same convention as the
    // shared 16->4 encoder: with several bits set the result is the OR of
    // their indices, with none set it is zero.
    function automatic logic [IDX_W-1:0] or_encode(input logic [TLBNUM-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < TLBNUM; i++) begin
            idx = idx | ({IDX_W{m[i]}} & IDX_W'(i));
        end
        return idx;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit
    // leaves something behind only if a second bit existed.
    function automatic logic multi_hit(input logic [TLBNUM-1:0] m);
        return (m & (m - {{(TLBNUM-1){1'b0}}, 1'b1})) != {TLBNUM{1'b0}};
    endfunction

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [TLBNUM-1:0] e_r;
    logic [TLBNUM-1:0] g_r;
    logic [VPPN_W-1:0] vppn_r [TLBNUM];
    logic [ASID_W-1:0] asid_r [TLBNUM];
    logic [PPN_W-1:0]  ppn_r  [TLBNUM];

    logic [TLBNUM-1:0] wr_sel_s;
    logic [TLBNUM-1:0] e_nxt_s;

    // Write-select decode and next e bits; a write to an entry wins over
    // a simultaneous invalidate-all for that entry.
    always_comb begin
        wr_sel_s = {TLBNUM{1'b0}};
        e_nxt_s  = e_r;
        for (int i = 0; i < TLBNUM; i++) begin
            wr_sel_s[i] = bus.we && (bus.w_index == IDX_W'(i));
            if (wr_sel_s[i]) begin
                e_nxt_s[i] = bus.w_e;
            end else if (bus.inv_all) begin
                e_nxt_s[i] = 1'b0;
            end else begin
                e_nxt_s[i] = e_r[i];
            end
        end
    end

    // Entry exists bits: the only entry state that reset has to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r <= {TLBNUM{1'b0}};
        end else begin
            e_r <= e_nxt_s;
        end
    end

    // Entry payload; meaningless while the e bit is clear, so not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TLBNUM; i++) begin
            if (wr_sel_s[i]) begin
                g_r[i]    <= bus.w_g;
                vppn_r[i] <= bus.w_vppn;
                asid_r[i] <= bus.w_asid;
                ppn_r[i]  <= bus.w_ppn;
            end
        end
    end

    // ------------------------------------------------------------------
    // Match against the entries as they stand before the edge
    // ------------------------------------------------------------------
    logic [TLBNUM-1:0] match_s;
    logic [PPN_W-1:0]  sel_ppn_s;

    // Per-entry compare and OR-select of the hit PPN.
    always_comb begin
        match_s   = {TLBNUM{1'b0}};
        sel_ppn_s = {PPN_W{1'b0}};
        for (int i = 0; i < TLBNUM; i++) begin
            match_s[i] = e_r[i]
                      && (vppn_r[i] == bus.s_vppn)
                      && (g_r[i] || (asid_r[i] == bus.s_asid));
            sel_ppn_s  = sel_ppn_s | ({PPN_W{match_s[i]}} & ppn_r[i]);
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic              a_valid_r;
    logic [TLBNUM-1:0] a_match_r;
    logic [PPN_W-1:0]  a_ppn_r;

    logic              b_valid_r;
    logic              b_found_r;
    logic              b_multi_r;
    logic [IDX_W-1:0]  b_index_r;
    logic [PPN_W-1:0]  b_ppn_r;

    logic              b_adv_s;
    logic              s_ready_s;

    // B can take new data when empty or being drained; A can take a new
    // request when empty or when its content moves on into B.
    always_comb begin
        b_adv_s   = !b_valid_r || bus.r_ready;
        s_ready_s = !a_valid_r || b_adv_s;
    end

    // Stage A: load on every cycle it is free to move; data only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_r <= 1'b0;
            a_match_r <= {TLBNUM{1'b0}};
            a_ppn_r   <= {PPN_W{1'b0}};
        end else if (s_ready_s) begin
            a_valid_r <= bus.s_valid;
            if (bus.s_valid) begin
                a_match_r <= match_s;
                a_ppn_r   <= sel_ppn_s;
            end
        end
    end

    // Stage B: reduce the match vector to the result fields. When A is
    // empty only the valid bit drops; the data fields keep their value.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_valid_r <= 1'b0;
            b_found_r <= 1'b0;
            b_multi_r <= 1'b0;
            b_index_r <= {IDX_W{1'b0}};
            b_ppn_r   <= {PPN_W{1'b0}};
        end else if (b_adv_s) begin
            b_valid_r <= a_valid_r;
            if (a_valid_r) begin
                b_found_r <= |a_match_r;
                b_multi_r <= multi_hit(a_match_r);
                b_index_r <= or_encode(a_match_r);
                b_ppn_r   <= a_ppn_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.s_ready = s_ready_s;
    assign bus.r_valid = b_valid_r;
    assign bus.r_found = b_found_r;
    assign bus.r_multi = b_multi_r;
    assign bus.r_index = b_index_r;
    assign bus.r_ppn   = b_ppn_r;

endmodule

// File: tb/tb_tlb_match_pipe.sv
// ----------------------------------------------------------------------------
// tb_tlb_match_pipe
// Directed scenarios followed by a randomized phase. Expected results come
// from a behavioural TLB model (plain arrays) plus an in-order queue of
// outstanding search results.
// ----------------------------------------------------------------------------
module tb_tlb_match_pipe;

    localparam int VPPN_W = 19;
    localparam int ASID_W = 10;
    localparam int PPN_W  = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tlb_match_pipe_if #(.VPPN_W(VPPN_W), .ASID_W(ASID_W), .PPN_W(PPN_W)) bus ();

    tlb_match_pipe #(.TLBNUM(16), .VPPN_W(VPPN_W), .ASID_W(ASID_W), .PPN_W(PPN_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic             found;
        logic             multi;
        logic [3:0]       index;
        logic [PPN_W-1:0] ppn;
    } res_t;

    // reference model state
    logic              m_e    [16];
    logic              m_g    [16];
    logic [VPPN_W-1:0] m_vppn [16];
    logic [ASID_W-1:0] m_asid [16];
    logic [PPN_W-1:0]  m_ppn  [16];
    res_t              exp_q  [$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lookup result straight from the rules: count hits, OR their indices and PPNs.
    function automatic res_t model_search(input logic [VPPN_W-1:0] v, input logic [ASID_W-1:0] a);
        res_t r;
        int   hits;
        r    = '0;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_e[i] && m_vppn[i] == v && (m_g[i] || m_asid[i] == a)) begin
                hits++;
                r.index = r.index | 4'(i);
                r.ppn   = r.ppn | m_ppn[i];
            end
        end
        r.found = (hits > 0);
        r.multi = (hits > 1);
        return r;
    endfunction

    // One clock: sample handshakes before the edge, update model, advance to next negedge.
    task automatic tick();
        logic acc;
        logic cons;
        res_t h;
        #1;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) m_e[i] = 1'b0;
            last_acc = 1'b0;
        end else begin
            acc  = bus.s_valid && bus.s_ready;
            cons = bus.r_valid && bus.r_ready;
            last_acc = acc;
            if (bus.r_valid) begin
                chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    h = exp_q[0];
                    chk("r_found", 32'(bus.r_found), 32'(h.found));
                    chk("r_multi", 32'(bus.r_multi), 32'(h.multi));
                    chk("r_index", 32'(bus.r_index), 32'(h.index));
                    chk("r_ppn",   32'(bus.r_ppn),   32'(h.ppn));
                    if (cons) void'(exp_q.pop_front());
                end
            end
            if (acc) exp_q.push_back(model_search(bus.s_vppn, bus.s_asid));
            if (bus.inv_all) begin
                for (int i = 0; i < 16; i++) m_e[i] = 1'b0;
            end
            if (bus.we) begin
                m_e[bus.w_index]    = bus.w_e;
                m_g[bus.w_index]    = bus.w_g;
                m_vppn[bus.w_index] = bus.w_vppn;
                m_asid[bus.w_index] = bus.w_asid;
                m_ppn[bus.w_index]  = bus.w_ppn;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] idx, input logic e, input logic g,
                      input logic [VPPN_W-1:0] v, input logic [ASID_W-1:0] a,
                      input logic [PPN_W-1:0] p);
        bus.we = 1'b1; bus.w_index = idx; bus.w_e = e; bus.w_g = g;
        bus.w_vppn = v; bus.w_asid = a; bus.w_ppn = p;
        tick();
        bus.we = 1'b0;
    endtask

    // Issue one search with the output stalled; leaves the result parked in stage B.
    task automatic probe(input logic [VPPN_W-1:0] v, input logic [ASID_W-1:0] a);
        bus.r_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_vppn = v; bus.s_asid = a;
        tick();
        chk("probe_accept", 32'(last_acc), 32'd1);
        bus.s_valid = 1'b0;
        chk("latency_not_yet", 32'(bus.r_valid), 32'd0);
        tick();
        chk("latency_valid", 32'(bus.r_valid), 32'd1);
    endtask

    task automatic drain();
        bus.r_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VPPN_W-1:0] rq_v [4];
        logic [ASID_W-1:0] rq_a [4];
        int sent;

        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_vppn = '0; bus.s_asid = '0; bus.r_ready = 1'b0;
        bus.we = 1'b0; bus.w_index = 4'd0; bus.w_e = 1'b0; bus.w_g = 1'b0;
        bus.w_vppn = '0; bus.w_asid = '0; bus.w_ppn = '0; bus.inv_all = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
        chk("rst_r_found", 32'(bus.r_found), 32'd0);
        chk("rst_r_multi", 32'(bus.r_multi), 32'd0);
        chk("rst_r_index", 32'(bus.r_index), 32'd0);
        chk("rst_r_ppn",   32'(bus.r_ppn),   32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // single hit
        wr(4'd5, 1'b1, 1'b0, 19'h12345, 10'h3, 20'hABCDE);
        probe(19'h12345, 10'h3);
        chk("t1_found", 32'(bus.r_found), 32'd1);
        chk("t1_index", 32'(bus.r_index), 32'd5);
        chk("t1_ppn",   32'(bus.r_ppn),   32'hABCDE);
        chk("t1_multi", 32'(bus.r_multi), 32'd0);
        drain();

        // ASID mismatch, then global
        probe(19'h12345, 10'h4);
        chk("t2_found", 32'(bus.r_found), 32'd0);
        chk("t2_index", 32'(bus.r_index), 32'd0);
        chk("t2_ppn",   32'(bus.r_ppn),   32'd0);
        drain();
        wr(4'd5, 1'b1, 1'b1, 19'h12345, 10'h3, 20'hABCDE);
        probe(19'h12345, 10'h4);
        chk("t2g_found", 32'(bus.r_found), 32'd1);
        chk("t2g_index", 32'(bus.r_index), 32'd5);
        drain();

        // multi hit
        wr(4'd2, 1'b1, 1'b1, 19'h7, 10'h0, 20'h22222);
        wr(4'd9, 1'b1, 1'b1, 19'h7, 10'h0, 20'h99999);
        probe(19'h7, 10'h55);
        chk("t3_found", 32'(bus.r_found), 32'd1);
        chk("t3_multi", 32'(bus.r_multi), 32'd1);
        chk("t3_index", 32'(bus.r_index), 32'hB);
        chk("t3_ppn",   32'(bus.r_ppn),   32'hBBBBB);
        drain();

        // back-to-back searches against a stalled output
        wr(4'd3, 1'b1, 1'b0, 19'h100, 10'h1, 20'h33333);
        rq_v[0] = 19'h12345; rq_a[0] = 10'h4;
        rq_v[1] = 19'h7;     rq_a[1] = 10'h0;
        rq_v[2] = 19'h100;   rq_a[2] = 10'h1;
        rq_v[3] = 19'h55555; rq_a[3] = 10'h0;
        sent = 0;
        bus.r_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.s_valid = (sent < 4);
            bus.s_vppn = rq_v[sent]; bus.s_asid = rq_a[sent];
            tick();
            if (last_acc) sent++;
        end
        chk("t4_accepts_stalled", 32'(sent), 32'd2);
        chk("t4_s_ready_low", 32'(bus.s_ready), 32'd0);
        chk("t4_r_valid_held", 32'(bus.r_valid), 32'd1);
        bus.r_ready = 1'b1;
        for (int c = 0; c < 20 && sent < 4; c++) begin
            bus.s_valid = 1'b1;
            bus.s_vppn = rq_v[sent]; bus.s_asid = rq_a[sent];
            tick();
            if (last_acc) sent++;
        end
        bus.s_valid = 1'b0;
        chk("t4_all_sent", 32'(sent), 32'd4);
        drain();
        chk("t4_no_duplicate", 32'(bus.r_valid), 32'd0);

        // inv_all together with a write
        bus.inv_all = 1'b1;
        wr(4'd1, 1'b1, 1'b0, 19'h11111, 10'h2, 20'h12121);
        bus.inv_all = 1'b0;
        probe(19'h11111, 10'h2);
        chk("t5_idx1_found", 32'(bus.r_found), 32'd1);
        chk("t5_idx1_index", 32'(bus.r_index), 32'd1);
        drain();
        probe(19'h12345, 10'h3);
        chk("t5_idx5_found", 32'(bus.r_found), 32'd0);
        drain();

        // reset with both stages full
        bus.r_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_vppn = 19'h11111; bus.s_asid = 10'h2;
        tick();
        tick();
        bus.s_valid = 1'b0;
        chk("t6_full_r_valid", 32'(bus.r_valid), 32'd1);
        chk("t6_full_s_ready", 32'(bus.s_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_r_valid", 32'(bus.r_valid), 32'd0);
        chk("t6_s_ready", 32'(bus.s_ready), 32'd1);
        probe(19'h11111, 10'h2);
        chk("t6_miss", 32'(bus.r_found), 32'd0);
        drain();

        // randomized traffic over a small tag space to get hits, misses and multi-hits
        for (int c = 0; c < 400; c++) begin
            bus.we      = ($urandom_range(0, 3) == 0);
            bus.w_index = 4'($urandom_range(0, 15));
            bus.w_e     = ($urandom_range(0, 3) != 0);
            bus.w_g     = 1'($urandom_range(0, 1));
            bus.w_vppn  = 19'($urandom_range(0, 3));
            bus.w_asid  = 10'($urandom_range(0, 1));
            bus.w_ppn   = 20'($urandom);
            bus.inv_all = ($urandom_range(0, 31) == 0);
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_vppn  = 19'($urandom_range(0, 3));
            bus.s_asid  = 10'($urandom_range(0, 1));
            bus.r_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.we = 1'b0; bus.inv_all = 1'b0; bus.s_valid = 1'b0;
        drain();
        chk("rand_end_idle", 32'(bus.r_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
